// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencer between the CPU MAR/MDR datapath and a
// synchronous single-port RAM. One request at a time: range check, RAM
// strobe sequencing, read-data capture into the MDR, optional wait
// states and a one-cycle completion pulse.
module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_READ    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);

    // State following any RAM access (or a rejected request).
    localparam logic [2:0] ST_POST = NO_WAIT ? ST_DONE : ST_WAIT;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mdr_q;
    logic              err_q;
    logic [3:0]        wait_cnt;
    logic              out_of_range;
    logic              accept;

    // Any set bit above the RAM address field means the word does not exist.
    assign out_of_range = (mem_addr >> ADDR_W) != '0;
    assign accept       = (state == ST_IDLE) && mem_req;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    if (out_of_range) state_nxt = ST_POST;
                    else if (mem_we)  state_nxt = ST_WRITE;
                    else              state_nxt = ST_READ;
                end
            end
            ST_WRITE:   state_nxt = ST_POST;
            ST_READ:    state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_POST;
            // Counter holds the remaining WAIT cycles including this one,
            // so leave when it is about to reach zero.
            ST_WAIT:    if (wait_cnt <= 4'd1) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Request latches: address, write data and range-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= mem_addr[ADDR_W-1:0];
            wdata_q <= mem_wdata;
            err_q   <= out_of_range;
        end
    end

    // MDR: loaded from the RAM in CAPTURE, cleared by a rejected read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr_q <= '0;
        end else if (state == ST_CAPTURE) begin
            mdr_q <= ram_data_out;
        end else if (accept && out_of_range && !mem_we) begin
            mdr_q <= '0;
        end
    end

    // Wait-state counter: loaded on entry to WAIT, decremented inside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_nxt == ST_WAIT && state != ST_WAIT) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == ST_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign mem_rdata        = mdr_q;
    assign mem_done         = (state == ST_DONE);
    assign mem_err          = (state == ST_DONE) && err_q;
    assign busy             = (state != ST_IDLE);
    assign ram_address      = addr_q;
    assign ram_data_in      = wdata_q;
    assign ram_write_enable = (state == ST_WRITE);
    assign ram_read_enable  = (state == ST_READ);

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the CPU datapath (MAR/MDR side) and the 256-word synchronous RAM. It accepts one read or write request at a time and drives the RAM's address, data-in, write-enable and read-enable pins with the correct cycle sequence. It captures the RAM's registered read data into an internal MDR and signals completion with a one-cycle done pulse. Out-of-range addresses are rejected without touching the RAM.

## Interface
- `DATA_W`, default 32: data word width.
- `ADDR_W`, default 8: RAM address width; the low `ADDR_W` bits of `mem_addr` are used.
- `WAIT_STATES`, default 0: extra idle cycles inserted before `DONE`, range 0–15.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `mem_req`, in, 1: request strobe; sampled only in `IDLE`.
- `mem_we`, in, 1: 1 = write, 0 = read; sampled with `mem_req`.
- `mem_addr`, in, 32: byte-free word address from the MAR.
- `mem_wdata`, in, `DATA_W`: write data; sampled with `mem_req`.
- `mem_rdata`, out, `DATA_W`: MDR, holding the last read result.
- `mem_done`, out, 1: one-cycle completion pulse.
- `mem_err`, out, 1: valid with `mem_done`; 1 = address out of range.
- `busy`, out, 1: high in every state except `IDLE`.
- `ram_address`, out, `ADDR_W`: address to the RAM.
- `ram_data_in`, out, `DATA_W`: write data to the RAM.
- `ram_write_enable`, out, 1: RAM write strobe.
- `ram_read_enable`, out, 1: RAM read strobe.
- `ram_data_out`, in, `DATA_W`: registered RAM read data, valid the cycle after `ram_read_enable`.

## Operation
- **States:** `IDLE`, `WRITE`, `READ`, `CAPTURE`, `WAIT`, `DONE`.
- **Acceptance.** In `IDLE` with `mem_req`=1, the block latches `mem_addr[ADDR_W-1:0]`, `mem_wdata` and `mem_we` into internal registers.
  - Range check: if `mem_addr[31:ADDR_W]` ≠ 0, set an error flag and go to `WAIT`. The RAM is never enabled.
  - Otherwise go to `WRITE` if `mem_we`=1, else `READ`.
- **`WRITE`:** `ram_write_enable`=1 for exactly this cycle. Next state is `WAIT`.
- **`READ`:** `ram_read_enable`=1 for exactly this cycle. Next state is `CAPTURE`.
- **`CAPTURE`:** MDR ← `ram_data_out` at the end of this cycle. Next state is `WAIT`.
- **`WAIT`:** a 4-bit counter loaded with `WAIT_STATES` on entry and decremented each cycle.
  - Exit to `DONE` when the counter is 0.
  - With `WAIT_STATES`=0, `WAIT` is skipped and the block goes directly to `DONE`.
- **`DONE`:** `mem_done`=1 and `mem_err` = error flag. Next state is always `IDLE`.
- **`mem_rdata`** is updated only in `CAPTURE`. On an error read it is cleared to 0. Writes leave it unchanged.
- **RAM outputs.** `ram_address` and `ram_data_in` are driven continuously from the latched registers. Both enables are decoded from the state register only and are never high together.
- **Ignored requests.** `mem_req` in any state other than `IDLE` is ignored; there is no queueing. The requester must hold `mem_req` or re-issue it after `mem_done`.
- **Back-to-back.** `mem_req` held high is accepted again on the first `IDLE` cycle after `DONE`.

## Timing
- **Reset.** `rst_n`=0 forces, asynchronously:
  - state → `IDLE`; `busy`, `mem_done`, `mem_err`, `ram_write_enable`, `ram_read_enable` → 0;
  - `mem_rdata`, `ram_address`, `ram_data_in` → 0; wait counter → 0.
- **Reset mid-operation** aborts the operation with no done pulse. A write already in `WRITE` may or may not have been committed by the RAM.
- **Latency**, counting from the acceptance edge (edge 0), with `W` = `WAIT_STATES`:
  - write: `WRITE` in cycle 1, `mem_done` in cycle 2+W;
  - read: `READ` in cycle 1, `CAPTURE` in cycle 2, `mem_done` in cycle 3+W. `mem_rdata` is valid from cycle 3 and stays stable until the next read completes;
  - range error: `mem_done`=1 with `mem_err`=1 in cycle 1+W.
- **`busy`** rises in cycle 1 and falls in the cycle after `DONE`.
- **Throughput** with W=0: one write per 3 cycles, one read per 4 cycles.

## Test plan
- **Reset state:** assert `rst_n`=0 mid-cycle → all outputs read 0 immediately, before any clock edge.
- **Write/read round trip:** write 0x12345678 to `mem_addr` 0x54, then read 0x54.
  - `ram_write_enable` is high for one cycle with `ram_address`=0x54.
  - `mem_rdata`=0x12345678, with `mem_done` in cycle 3 of the read and `mem_err`=0.
- **Preloaded read:** read 0x92 against a RAM model preloaded with 0x00000046 → `mem_rdata`=0x46 and `ram_read_enable` is high for exactly one cycle.
- **Out-of-range:** read `mem_addr` 0x00000100 → neither RAM enable ever rises, `mem_done` and `mem_err` are 1 in cycle 1, and `mem_rdata`=0.
- **Wait states and ignored request:** with `WAIT_STATES`=2, write 0xAA to 0x55 while pulsing `mem_req` again in cycle 2 with `mem_we`=0.
  - `mem_done` arrives in cycle 4 and only one RAM write occurs.
  - No read is issued.
- **Reset mid-read:** drop `rst_n` during `CAPTURE` → no `mem_done` and `mem_rdata`=0. The next request after reset release completes normally.
